// File: rtl/chaotic_stream_cipher_if.sv
// Pixel stream bundle for the chaotic stream cipher: input and output valid/ready channels.
// The master modport is the source/sink side; the slave modport is the cipher.
interface chaotic_stream_cipher_if #(
    parameter int CH = 3,
    parameter int DW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*DW-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH*DW-1:0]     out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/chaotic_stream_cipher.sv
// Streaming pixel cipher: XORs each channel with a Galois LFSR keystream slice,
// with optional ciphertext chaining. Decrypt is the same datapath with the same seed.
module chaotic_stream_cipher #(
    parameter int            CH   = 3,
    parameter int            DW   = 8,
    parameter int            NPIX = 65536,
    parameter int            LW   = 32,
    parameter logic [LW-1:0] TAP  = 32'h80200003
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LW-1:0]              seed,
    input  logic                       mode,
    input  logic                       dir,
    chaotic_stream_cipher_if.slave     bus,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NPIX+1)-1:0]  pix_count
);
    // Keystream is the low CH*DW bits of the LFSR, so CH*DW must not exceed LW.
    localparam int            PW   = CH * DW;
    localparam int            CW   = $clog2(NPIX + 1);
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state;
    logic [LW-1:0] lfsr;
    logic [PW-1:0] chain;
    logic [CW-1:0] in_cnt;
    logic          mode_q;
    logic          dir_q;
    logic          in_hs;
    logic          out_hs;
    logic [PW-1:0] key;
    logic [PW-1:0] enc;

    assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign out_hs       = bus.out_valid && bus.out_ready;
    assign key          = lfsr[PW-1:0];
    assign enc          = bus.in_data ^ key ^ (mode_q ? chain : '0);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= LW'(1);
            chain         <= '0;
            in_cnt        <= '0;
            pix_count     <= '0;
            mode_q        <= 1'b0;
            dir_q         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr          <= (seed == '0) ? LW'(1) : seed;
                        mode_q        <= mode;
                        dir_q         <= dir;
                        chain         <= '0;
                        in_cnt        <= '0;
                        pix_count     <= '0;
                        bus.out_valid <= 1'b0;
                        state         <= RUN;
                    end
                end
                RUN, FLUSH: begin
                    if (out_hs) begin
                        bus.out_valid <= 1'b0;
                        pix_count     <= pix_count + 1'b1;
                    end
                    // A new pixel overrides the drop of out_valid, giving back-to-back throughput.
                    if (in_hs) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= enc;
                        lfsr          <= (lfsr >> 1) ^ (lfsr[0] ? TAP : '0);
                        if (mode_q)
                            chain <= dir_q ? bus.in_data : enc;
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LAST)
                            state <= FLUSH;
                    end
                    // In FLUSH the output register can only hold the final pixel.
                    if (state == FLUSH && out_hs)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
